clk_div_bank: RTL

Multi-channel programmable clock-enable generator. It is the parametrised successor to the single fixed power-of-two slow-clock counter. Each channel divides clk by a run-time loadable integer and produces either a square wave (toggle mode) or a one-cycle enable pulse (tick mode). It feeds display multiplexing, debouncers and blink logic, so these no longer need separately sized counters.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_channel.sv | 81 ++++++++
 rtl/clk_div_bank.sv | 70 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Types and constants shared by the clock-enable divider bank.
//   div_mode_e : channel output mode (square wave or one-cycle tick copy)
//   DEFAULT_W  : default counter/divisor width
//   ch_cfg_t   : per-channel configuration record at the default width
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DEFAULT_W = 28;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_TICK   = 1'b1
    } div_mode_e;

    typedef struct packed {
        logic [DEFAULT_W-1:0] div;
        div_mode_e            mode;
    } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
// One divider channel: config register (divisor + mode), counter and
// registered outputs.
//   clk      in   system clock
//   RESET_N  in   async active-low reset
//   en       in   count enable
//   clr      in   synchronous restart (config kept)
//   ld_sel   in   load this channel's config on the next edge
//   ld_div   in   new divisor (0 disables the channel)
//   ld_mode  in   new mode: 0 toggle, 1 tick
//   clk_out  out  square wave (toggle) or copy of tick (tick mode)
//   tick     out  one-cycle pulse on terminal count
// ---------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         RESET_N,
    input  logic         en,
    input  logic         clr,
    input  logic         ld_sel,
    input  logic [W-1:0] ld_div,
    input  logic         ld_mode,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] r_div;
    div_mode_e    r_mode;
    logic [W-1:0] r_cnt;
    logic         r_clk_out;
    logic         r_tick;

    logic         w_terminal;

    // Only meaningful when r_div != 0; the zero-divisor case is handled
    // ahead of this in the priority chain.
    assign w_terminal = (r_cnt == (r_div - W'(1)));

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div     <= W'(DEFAULT_DIV);
            r_mode    <= MODE_TOGGLE;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (ld_sel) begin
            // A load always restarts the channel, so cnt can never sit
            // above the new div-1. It also beats a coincident terminal count.
            r_div     <= ld_div;
            r_mode    <= div_mode_e'(ld_mode);
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (clr || (r_div == '0)) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!en) begin
            // Freeze the phase; pulses are suppressed rather than deferred.
            r_tick <= 1'b0;
            if (r_mode == MODE_TICK) r_clk_out <= 1'b0;
        end else if (w_terminal) begin
            r_cnt     <= '0;
            r_tick    <= 1'b1;
            r_clk_out <= (r_mode == MODE_TICK) ? 1'b1 : ~r_clk_out;
        end else begin
            r_cnt  <= r_cnt + W'(1);
            r_tick <= 1'b0;
            if (r_mode == MODE_TICK) r_clk_out <= 1'b0;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH programmable clock-enable dividers.
//   clk      in   system clock
//   RESET_N  in   async active-low reset
//   en       in   global count enable
//   clr      in   synchronous restart of all channels
//   ld       in   load strobe for one channel's config
//   ld_ch    in   channel index for the load
//   ld_div   in   new divisor
//   ld_mode  in   new mode: 0 toggle, 1 tick
//   clk_out  out  per-channel output
//   tick     out  per-channel terminal-count pulse
//   ld_err   out  one-cycle pulse for a load to a nonexistent channel
// ---------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int W           = DEFAULT_W,
    parameter  int DEFAULT_DIV = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              en,
    input  logic              clr,
    input  logic              ld,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [W-1:0]      ld_div,
    input  logic              ld_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              ld_err
);

    logic [NUM_CH-1:0] w_ld_sel;
    logic              w_ld_bad;
    logic              r_ld_err;

    // Out-of-range index: no channel selected, error flagged instead.
    assign w_ld_bad = ld && (32'(ld_ch) >= NUM_CH);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) r_ld_err <= 1'b0;
        else          r_ld_err <= w_ld_bad;
    end

    assign ld_err = r_ld_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_ld_sel[i] = ld && (32'(ld_ch) == i);

        clk_div_channel #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .RESET_N (RESET_N),
            .en      (en),
            .clr     (clr),
            .ld_sel  (w_ld_sel[i]),
            .ld_div  (ld_div),
            .ld_mode (ld_mode),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
